// File: rtl/vend_pkg.sv
// Shared types and constants for the coin-vending sequencing controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND1  = 2'd1,
        VEND2  = 2'd2,
        CHANGE = 2'd3
    } state_t;

    // Coin values in nickel units
    localparam int unsigned NIC_VAL = 1;
    localparam int unsigned DIM_VAL = 2;

    // Default sizing and pricing
    localparam int unsigned DEF_CREDIT_W = 4;
    localparam int unsigned DEF_PRICE1   = 3;
    localparam int unsigned DEF_PRICE2   = 4;
    localparam int unsigned DEF_CHG_GAP  = 4;

endpackage

// File: rtl/vend_if.sv
// Front-panel inputs and actuator outputs of the vending controller.
interface vend_if
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W = DEF_CREDIT_W
);
    logic                nic;
    logic                dim;
    logic                obj1;
    logic                obj2;
    logic                ch;
    logic [CREDIT_W-1:0] credit;
    logic                vend1;
    logic                vend2;
    logic                chg;
    logic                rej;
    logic                busy;

    modport master (
        output nic, dim, obj1, obj2, ch,
        input  credit, vend1, vend2, chg, rej, busy
    );

    modport slave (
        input  nic, dim, obj1, obj2, ch,
        output credit, vend1, vend2, chg, rej, busy
    );
endinterface

// File: rtl/vend_edge_det.sv
// One-bit rising-edge detector; prev follows the input every cycle,
// including during reset, so a level held through reset gives no edge.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise_c
);
    logic prev;

    // Track previous input level (reset loads the live input value)
    always_ff @(posedge clk) begin
        prev <= din;
    end

    assign rise_c = din & ~prev & ~rst;
endmodule

// File: rtl/vend_ctrl.sv
// Coin-vending sequencing controller: credit keeping, product arbitration,
// dispense strobes and paced change return.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W = DEF_CREDIT_W,
    parameter int unsigned PRICE1   = DEF_PRICE1,
    parameter int unsigned PRICE2   = DEF_PRICE2,
    parameter int unsigned CHG_GAP  = DEF_CHG_GAP
) (
    input  logic  clk,
    input  logic  rst,
    vend_if.slave bus
);
    localparam int unsigned GAP_W      = $clog2(CHG_GAP);
    localparam int unsigned SUM_W      = CREDIT_W + 1;
    localparam int unsigned CREDIT_MAX = (1 << CREDIT_W) - 1;

    logic nic_e, dim_e, obj1_e, obj2_e, ch_e, coin_e;

    edge_det u_nic  (.clk(clk), .rst(rst), .din(bus.nic),  .rise_c(nic_e));
    edge_det u_dim  (.clk(clk), .rst(rst), .din(bus.dim),  .rise_c(dim_e));
    edge_det u_obj1 (.clk(clk), .rst(rst), .din(bus.obj1), .rise_c(obj1_e));
    edge_det u_obj2 (.clk(clk), .rst(rst), .din(bus.obj2), .rise_c(obj2_e));
    edge_det u_ch   (.clk(clk), .rst(rst), .din(bus.ch),   .rise_c(ch_e));

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit_q, credit_n;
    logic [GAP_W-1:0]    gap_q, gap_n;
    logic                rej_n;
    logic                vend1_q, vend2_q, chg_q, rej_q, busy_q;
    logic [SUM_W-1:0]    coin_val, sum;

    // Coin value of this cycle's edges and the widened candidate balance
    always_comb begin
        coin_e   = nic_e | dim_e;
        coin_val = SUM_W'(nic_e ? NIC_VAL : 0) + SUM_W'(dim_e ? DIM_VAL : 0);
        sum      = {1'b0, credit_q} + coin_val;
    end

    // Next-state, credit and refusal decode
    always_comb begin
        state_n  = state;
        credit_n = credit_q;
        gap_n    = gap_q;
        rej_n    = 1'b0;
        case (state)
            IDLE: begin
                gap_n = '0;
                if (ch_e && credit_q != '0) begin
                    state_n = CHANGE;
                end else if (obj1_e && credit_q >= CREDIT_W'(PRICE1)) begin
                    state_n  = VEND1;
                    credit_n = credit_q - CREDIT_W'(PRICE1);
                end else if (obj2_e && credit_q >= CREDIT_W'(PRICE2)) begin
                    state_n  = VEND2;
                    credit_n = credit_q - CREDIT_W'(PRICE2);
                end
                // Coins are refused when leaving IDLE or when the sum would overflow
                if (coin_e) begin
                    if (state_n != IDLE || sum > SUM_W'(CREDIT_MAX)) begin
                        rej_n = 1'b1;
                    end else begin
                        credit_n = sum[CREDIT_W-1:0];
                    end
                end
            end
            VEND1, VEND2: begin
                state_n = IDLE;
                rej_n   = coin_e;
            end
            CHANGE: begin
                rej_n = coin_e;
                gap_n = (gap_q == GAP_W'(CHG_GAP - 1)) ? '0 : gap_q + GAP_W'(1);
                if (gap_q == '0) begin
                    credit_n = credit_q - CREDIT_W'(1);
                    if (credit_q == CREDIT_W'(1)) begin
                        state_n = IDLE;
                        gap_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gap_n   = '0;
            end
        endcase
    end

    // State, credit and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            credit_q <= '0;
            gap_q    <= '0;
            vend1_q  <= 1'b0;
            vend2_q  <= 1'b0;
            chg_q    <= 1'b0;
            rej_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            credit_q <= credit_n;
            gap_q    <= gap_n;
            vend1_q  <= (state_n == VEND1);
            vend2_q  <= (state_n == VEND2);
            chg_q    <= (state_n == CHANGE) && (gap_n == '0);
            rej_q    <= rej_n;
            busy_q   <= (state_n != IDLE);
        end
    end

    assign bus.credit = credit_q;
    assign bus.vend1  = vend1_q;
    assign bus.vend2  = vend2_q;
    assign bus.chg    = chg_q;
    assign bus.rej    = rej_q;
    assign bus.busy   = busy_q;
endmodule
